axis2wb: RTL and testbench
==========================

// Module: axis2wb
// PURPOSE
//  AXI4-Stream byte sink, a Wishbone-readable FIFO; the receive-side counterpart of the wb2axis byte transmitter.
//  Buffers incoming bytes and their tlast flags so firmware running on the SERV core can poll or pop them.
//  Sits on the base data-bus mux as one more Wishbone slave, next to the timer and the transmit FIFO.
// PARAMETERS
//  DEPTH  16  FIFO entries of 9 bits {tlast,tdata}; power of two, >=2
// PORTS
//  i_clk      in   1   system clock; single clock domain
//  i_rst_n    in   1   reset, asynchronous assert, active-low
//  i_wb_adr   in   1   register select: 0=DATA, 1=CTRL/STATUS (word address bit 2)
//  i_wb_dat   in   32  write data
//  i_wb_we    in   1   write enable
//  i_wb_stb   in   1   access request
//  o_wb_rdt   out  32  read data
//  o_wb_ack   out  1   access acknowledge
//  i_tdata    in   8   stream byte
//  i_tlast    in   1   end-of-packet flag
//  i_tvalid   in   1   stream beat valid
//  o_tready   out  1   sink ready
//  o_irq      out  1   data-available interrupt
// BEHAVIOUR
//  Reset: FIFO empty, count=0, irq_en=0, o_wb_ack=0, o_wb_rdt=0, o_irq=0, o_tready=0 while i_rst_n low.
//  Stream: o_tready = !full (registered state only). Beat accepted when i_tvalid&o_tready, pushed same edge.
//  Wishbone: o_wb_ack <= i_wb_stb & !o_wb_ack, so one ack per access, 1 cycle after stb; o_wb_rdt registered on that edge.
//  DATA read (adr0): if !empty -> rdt={1'b1,22'b0,tlast,tdata} of head entry, entry popped on the ack edge.
//    If empty -> rdt=32'h0, no pop. Bit31 is the valid flag for firmware.
//  DATA write: ignored, acked.
//  CTRL read (adr1): rdt[15:0]=count (zero-ext), [16]=empty, [17]=full, [18]=irq_en, rest 0.
//  CTRL write: [0]=1 flush (count->0, pointers reset), [1]=irq_en. Takes effect on the ack edge.
//  Access side effects (pop/flush) occur only on the edge where o_wb_ack rises, never twice per stb.
//  o_irq = irq_en & !empty, registered.
//  Count: width $clog2(DEPTH)+1, range 0..DEPTH. Pointers $clog2(DEPTH) bits, wrap modulo DEPTH.
//  Simultaneous push+pop: count unchanged, both pointers advance; legal at full (push blocked anyway) and at count=1.
//  Pop while empty + push same edge: pushed byte retained, read returns 0.
//  Flush + push same edge: flush wins, that beat is discarded (handshake still completes).
//  Reset mid-packet: FIFO contents lost; upstream must restart packet.
//  No flow-through: a byte pushed on edge N is readable by an access starting at N+1 or later.
// STRUCTURE
//  Shared constants in base_pkg (include): AXIS2WB_REG_DATA=0, AXIS2WB_REG_CTRL=1, bit positions
//    VALID=31, EMPTY=16, FULL=17, IRQEN=18, FLUSH=0 — also used by firmware headers.
//  One sub-module: axis2wb_fifo (sync FIFO, DEPTH x 9, push/pop/flush, count/empty/full outputs,
//    async active-low reset on pointers/count; storage unreset, inferrable as distributed RAM).
//  Top holds Wishbone decode, ack, irq_en, read mux.
// TESTING
//  1 Reset, read CTRL -> rdt=32'h0001_0000 (empty, count 0); read DATA -> 32'h0.
//  2 Send bytes 8'hA5, 8'h3C(tlast) -> CTRL count=2; DATA reads 32'h8000_00A5 then 32'h8000_013C; then 32'h0.
//  3 Push 16 bytes with tvalid held -> o_tready low after 16th, full=1; one DATA pop -> tready high, 17th byte accepted, order preserved.
//  4 Continuous stream + continuous DATA reads (push/pop same edge) over 100 bytes incl. pointer wrap -> no loss, no duplicate.
//  5 Write CTRL=32'h2, send 1 byte -> o_irq=1; pop it -> o_irq=0; write CTRL=32'h1 with 5 queued -> count=0, irq low.
//  6 Assert i_rst_n low mid-packet with 7 queued -> all outputs reset immediately, count=0 after release.

Source files
------------

// File: rtl/axis2wb_pkg.sv
// Shared register map, bit positions and entry type for the axis2wb byte sink.
// Firmware headers mirror these constants.
package axis2wb_pkg;

    localparam int unsigned AXIS2WB_DEPTH_DEF = 16;

    // Register select (Wishbone word address bit 2)
    localparam logic AXIS2WB_REG_DATA = 1'b0;
    localparam logic AXIS2WB_REG_CTRL = 1'b1;

    // DATA read word
    localparam int unsigned AXIS2WB_BIT_VALID = 31;

    // CTRL/STATUS read word
    localparam int unsigned AXIS2WB_BIT_EMPTY = 16;
    localparam int unsigned AXIS2WB_BIT_FULL  = 17;
    localparam int unsigned AXIS2WB_BIT_IRQEN = 18;

    // CTRL write word
    localparam int unsigned AXIS2WB_BIT_FLUSH    = 0;
    localparam int unsigned AXIS2WB_BIT_IRQEN_WR = 1;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } axis2wb_entry_t;

    // Firmware-visible DATA word for a valid head entry
    function automatic logic [31:0] axis2wb_data_word(input axis2wb_entry_t e);
        logic [31:0] w;
        w                    = '0;
        w[AXIS2WB_BIT_VALID] = 1'b1;
        w[8:0]               = e;
        return w;
    endfunction

endpackage

// File: rtl/axis2wb_if.sv
// Wishbone slave port plus AXI4-Stream sink port of axis2wb, bundled.
// Signal names keep the block's documented port names.
interface axis2wb_if;

    logic        i_wb_adr;
    logic [31:0] i_wb_dat;
    logic        i_wb_we;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    logic [7:0]  i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        output o_wb_rdt, o_wb_ack,
        input  i_tdata, i_tlast, i_tvalid,
        output o_tready
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_we, i_wb_stb,
        input  o_wb_rdt, o_wb_ack,
        output i_tdata, i_tlast, i_tvalid,
        input  o_tready
    );

endinterface

// File: rtl/axis2wb_fifo.sv
// Synchronous DEPTH x 9 FIFO with flush. Pointers and count are reset;
// storage is not, so it can map onto distributed RAM.
module axis2wb_fifo
    import axis2wb_pkg::*;
#(
    parameter  int unsigned DEPTH = AXIS2WB_DEPTH_DEF,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_push,
    input  logic           i_pop,
    input  logic           i_flush,
    input  axis2wb_entry_t i_wdata,
    output axis2wb_entry_t o_rdata,
    output logic [CW-1:0]  o_count,
    output logic           o_empty,
    output logic           o_full
);

    axis2wb_entry_t mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q,  count_d;
    logic           do_push, do_pop;

    assign o_empty = (count_q == '0);
    assign o_full  = (count_q == CW'(DEPTH));
    assign o_rdata = mem_q[rd_ptr_q];

    // Requests against empty/full are dropped; flush overrides both.
    assign do_push = i_push & ~o_full  & ~i_flush;
    assign do_pop  = i_pop  & ~o_empty & ~i_flush;

    // Next pointer/count; pointers wrap naturally since DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (i_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and count registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port
    always_ff @(posedge i_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= i_wdata;
    end

    assign o_count = count_q;

endmodule

// File: rtl/axis2wb.sv
// AXI4-Stream byte sink exposed to firmware as a two-register Wishbone slave.
// DATA read pops the head entry; CTRL read returns status, CTRL write flushes
// and sets the interrupt enable.
module axis2wb
    import axis2wb_pkg::*;
#(
    parameter int unsigned DEPTH = AXIS2WB_DEPTH_DEF
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    axis2wb_if.slave  bus,
    output logic      o_irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic           ack_q, ack_d;
    logic [31:0]    rdt_q, rdt_d;
    logic           irq_en_q, irq_en_d;
    logic           irq_q, irq_d;
    logic           rdy_q;

    logic           access;
    logic           fifo_push, fifo_pop, fifo_flush;
    axis2wb_entry_t fifo_wdata, fifo_rdata;
    logic [CW-1:0]  fifo_count;
    logic           fifo_empty, fifo_full;
    logic           unused_dat;

    // Side effects happen only on the edge that raises ack.
    assign access     = bus.i_wb_stb & ~ack_q;
    assign fifo_pop   = access & ~bus.i_wb_we & (bus.i_wb_adr == AXIS2WB_REG_DATA);
    assign fifo_flush = access &  bus.i_wb_we & (bus.i_wb_adr == AXIS2WB_REG_CTRL)
                      & bus.i_wb_dat[AXIS2WB_BIT_FLUSH];

    // rdy_q keeps tready low while in reset and for the first edge after it.
    assign bus.o_tready = rdy_q & ~fifo_full;
    assign fifo_push    = bus.i_tvalid & bus.o_tready;
    assign fifo_wdata   = '{last: bus.i_tlast, data: bus.i_tdata};

    assign unused_dat = ^bus.i_wb_dat[31:2];

    axis2wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (fifo_push),
        .i_pop   (fifo_pop),
        .i_flush (fifo_flush),
        .i_wdata (fifo_wdata),
        .o_rdata (fifo_rdata),
        .o_count (fifo_count),
        .o_empty (fifo_empty),
        .o_full  (fifo_full)
    );

    // Ack, read mux, irq enable and interrupt next-state
    always_comb begin
        ack_d    = bus.i_wb_stb & ~ack_q;
        rdt_d    = rdt_q;
        irq_en_d = irq_en_q;
        irq_d    = irq_en_q & ~fifo_empty;
        if (access) begin
            rdt_d = '0;
            if (bus.i_wb_we) begin
                if (bus.i_wb_adr == AXIS2WB_REG_CTRL)
                    irq_en_d = bus.i_wb_dat[AXIS2WB_BIT_IRQEN_WR];
            end else if (bus.i_wb_adr == AXIS2WB_REG_DATA) begin
                if (!fifo_empty) rdt_d = axis2wb_data_word(fifo_rdata);
            end else begin
                rdt_d[15:0]              = 16'(fifo_count);
                rdt_d[AXIS2WB_BIT_EMPTY] = fifo_empty;
                rdt_d[AXIS2WB_BIT_FULL]  = fifo_full;
                rdt_d[AXIS2WB_BIT_IRQEN] = irq_en_q;
            end
        end
    end

    // Bus-side registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_q    <= 1'b0;
            rdt_q    <= '0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            ack_q    <= ack_d;
            rdt_q    <= rdt_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rdy_q    <= 1'b1;
        end
    end

    assign bus.o_wb_ack = ack_q;
    assign bus.o_wb_rdt = rdt_q;
    assign o_irq        = irq_q;

endmodule

// File: tb/tb_axis2wb.sv
// Directed self-checking bench for axis2wb.
module tb_axis2wb;
    import axis2wb_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic irq;

    axis2wb_if bus ();

    axis2wb #(.DEPTH(16)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_irq   (irq)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wb_access(input logic adr, input logic we, input logic [31:0] dat,
                             output logic [31:0] rdt);
        logic got;
        got = 1'b0;
        rdt = '0;
        @(posedge clk); #1;
        bus.i_wb_adr = adr;
        bus.i_wb_we  = we;
        bus.i_wb_dat = dat;
        bus.i_wb_stb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (bus.o_wb_ack) begin
                got = 1'b1;
                rdt = bus.o_wb_rdt;
                break;
            end
        end
        bus.i_wb_stb = 1'b0;
        bus.i_wb_we  = 1'b0;
        check("wb_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic rd(input logic adr, output logic [31:0] v);
        wb_access(adr, 1'b0, 32'h0, v);
    endtask

    task automatic wr(input logic adr, input logic [31:0] d);
        logic [31:0] dummy;
        wb_access(adr, 1'b1, d, dummy);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        ok = 1'b0;
        bus.i_tdata  = d;
        bus.i_tlast  = l;
        bus.i_tvalid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (bus.o_tready) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        bus.i_tvalid = 1'b0;
        check("axis_accept", {31'b0, ok}, 32'd1);
    endtask

    function automatic logic [31:0] dword(input logic l, input logic [7:0] d);
        return {1'b1, 22'b0, l, d};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;

        bus.i_wb_adr = 1'b0;
        bus.i_wb_dat = '0;
        bus.i_wb_we  = 1'b0;
        bus.i_wb_stb = 1'b0;
        bus.i_tdata  = '0;
        bus.i_tlast  = 1'b0;
        bus.i_tvalid = 1'b0;

        // 1: reset state
        #1;
        check("rst_tready", {31'b0, bus.o_tready}, 32'd0);
        check("rst_ack",    {31'b0, bus.o_wb_ack}, 32'd0);
        check("rst_rdt",    bus.o_wb_rdt, 32'h0);
        check("rst_irq",    {31'b0, irq}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("ready_after_rst", {31'b0, bus.o_tready}, 32'd1);
        rd(AXIS2WB_REG_CTRL, v);
        check("t1_ctrl", v, 32'h0001_0000);
        rd(AXIS2WB_REG_DATA, v);
        check("t1_data_empty", v, 32'h0);

        // 2: two bytes, in order, tlast carried
        send_byte(8'hA5, 1'b0);
        send_byte(8'h3C, 1'b1);
        rd(AXIS2WB_REG_CTRL, v);
        check("t2_ctrl", v, 32'h0000_0002);
        rd(AXIS2WB_REG_DATA, v);
        check("t2_data0", v, 32'h8000_00A5);
        rd(AXIS2WB_REG_DATA, v);
        check("t2_data1", v, 32'h8000_013C);
        rd(AXIS2WB_REG_DATA, v);
        check("t2_data_empty", v, 32'h0);

        // 3: fill to full, backpressure, pop releases one slot
        for (int i = 0; i < 16; i++) send_byte(8'(8'h10 + i), 1'b0);
        check("t3_full_tready", {31'b0, bus.o_tready}, 32'd0);
        rd(AXIS2WB_REG_CTRL, v);
        check("t3_ctrl_full", v, 32'h0002_0010);
        bus.i_tdata  = 8'h20;
        bus.i_tlast  = 1'b1;
        bus.i_tvalid = 1'b1;
        @(posedge clk); #1;
        check("t3_blocked", {31'b0, bus.o_tready}, 32'd0);
        rd(AXIS2WB_REG_DATA, v);
        check("t3_pop_head", v, 32'h8000_0010);
        check("t3_ready_again", {31'b0, bus.o_tready}, 32'd1);
        @(posedge clk); #1;
        bus.i_tvalid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rd(AXIS2WB_REG_DATA, v);
            check($sformatf("t3_drain_%0d", i), v, dword(i == 15, 8'(8'h11 + i)));
        end
        rd(AXIS2WB_REG_DATA, v);
        check("t3_drained", v, 32'h0);

        // 4: concurrent stream and reads, 100 bytes with pointer wrap
        fork
            begin
                for (int k = 0; k < 100; k++) send_byte(8'(k * 7 + 3), (k % 10) == 9);
            end
            begin : consumer
                logic [31:0] rv;
                int idx;
                idx = 0;
                for (int a = 0; a < 1000 && idx < 100; a++) begin
                    rd(AXIS2WB_REG_DATA, rv);
                    if (rv[31]) begin
                        check($sformatf("t4_byte_%0d", idx), rv,
                              dword((idx % 10) == 9, 8'(idx * 7 + 3)));
                        idx++;
                    end else begin
                        check("t4_empty_zero", rv, 32'h0);
                    end
                end
                check("t4_count", idx, 32'd100);
            end
        join
        rd(AXIS2WB_REG_CTRL, v);
        check("t4_ctrl_end", v, 32'h0001_0000);

        // 5: interrupt enable, irq timing, flush
        wr(AXIS2WB_REG_CTRL, 32'h2);
        send_byte(8'h55, 1'b1);
        check("t5_irq_lag", {31'b0, irq}, 32'd0);
        @(posedge clk); #1;
        check("t5_irq_set", {31'b0, irq}, 32'd1);
        rd(AXIS2WB_REG_DATA, v);
        check("t5_pop", v, 32'h8000_0155);
        @(posedge clk); #1;
        check("t5_irq_clr", {31'b0, irq}, 32'd0);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h60 + i), 1'b0);
        @(posedge clk); #1;
        check("t5_irq_5q", {31'b0, irq}, 32'd1);
        rd(AXIS2WB_REG_CTRL, v);
        check("t5_ctrl_5q", v, 32'h0004_0005);
        wr(AXIS2WB_REG_CTRL, 32'h1);
        rd(AXIS2WB_REG_CTRL, v);
        check("t5_ctrl_flushed", v, 32'h0001_0000);
        check("t5_irq_flushed", {31'b0, irq}, 32'd0);
        rd(AXIS2WB_REG_DATA, v);
        check("t5_data_flushed", v, 32'h0);

        // 5b: flush and push on the same edge -> beat discarded
        wr(AXIS2WB_REG_CTRL, 32'h2);
        fork
            wr(AXIS2WB_REG_CTRL, 32'h3);
            begin
                @(posedge clk); #1;
                bus.i_tdata  = 8'h77;
                bus.i_tlast  = 1'b0;
                bus.i_tvalid = 1'b1;
                @(posedge clk); #1;
                bus.i_tvalid = 1'b0;
            end
        join
        rd(AXIS2WB_REG_CTRL, v);
        check("t5b_flush_wins", v, 32'h0005_0000);
        check("t5b_irq", {31'b0, irq}, 32'd0);
        wr(AXIS2WB_REG_CTRL, 32'h0);

        // 6: reset mid-packet
        wr(AXIS2WB_REG_CTRL, 32'h2);
        for (int i = 0; i < 7; i++) send_byte(8'(8'h80 + i), 1'b0);
        rd(AXIS2WB_REG_CTRL, v);
        check("t6_ctrl_7q", v, 32'h0004_0007);
        @(posedge clk); #1;
        check("t6_irq_pre", {31'b0, irq}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_tready", {31'b0, bus.o_tready}, 32'd0);
        check("t6_rst_irq",    {31'b0, irq}, 32'd0);
        check("t6_rst_ack",    {31'b0, bus.o_wb_ack}, 32'd0);
        check("t6_rst_rdt",    bus.o_wb_rdt, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("t6_ready", {31'b0, bus.o_tready}, 32'd1);
        rd(AXIS2WB_REG_CTRL, v);
        check("t6_ctrl", v, 32'h0001_0000);
        rd(AXIS2WB_REG_DATA, v);
        check("t6_data", v, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
